// File: rtl/motor_status_tx.sv
// motor_status_tx: encodes a captured motor/direction/degree report as a
// 9-byte ASCII frame ("M<m>D<d><hhh>\r\n") and hands it to uart_tx one byte
// at a time over the start/ready handshake, aborting on a missing ack.
module motor_status_tx #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_report,
  input  logic [2:0] i_motor,
  input  logic       i_direction,
  input  logic [8:0] i_degrees,
  input  logic       i_ready,
  output logic       o_start,
  output logic [7:0] o_data,
  output logic       o_busy,
  output logic       o_drop,
  output logic       o_error
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CONV_H,
    CONV_T,
    LOAD,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [2:0]    motor;
  logic          direction;
  logic [8:0]    rem;
  logic [3:0]    hund;
  logic [3:0]    tens;
  logic [3:0]    idx;
  logic [TW-1:0] tmo;
  logic [7:0]    frame_byte;

  // Byte of the frame at the current index; units digit is what is left in rem
  always_comb begin
    frame_byte = 8'h0A;
    case (idx)
      4'd0:    frame_byte = 8'h4D;
      4'd1:    frame_byte = {5'b00110, motor};
      4'd2:    frame_byte = 8'h44;
      4'd3:    frame_byte = {7'b0011000, direction};
      4'd4:    frame_byte = {4'h3, hund};
      4'd5:    frame_byte = {4'h3, tens};
      4'd6:    frame_byte = {4'h3, rem[3:0]};
      4'd7:    frame_byte = 8'h0D;
      default: frame_byte = 8'h0A;
    endcase
  end

  // Frame sequencer: capture, decimal conversion, byte handshake, timeout
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= IDLE;
      motor     <= '0;
      direction <= 1'b0;
      rem       <= '0;
      hund      <= '0;
      tens      <= '0;
      idx       <= '0;
      tmo       <= '0;
      o_start   <= 1'b0;
      o_data    <= '0;
      o_busy    <= 1'b0;
      o_drop    <= 1'b0;
      o_error   <= 1'b0;
    end else begin
      o_start <= 1'b0;
      o_drop  <= 1'b0;
      o_error <= 1'b0;
      // Any request not seen in IDLE at the edge is dropped, including the
      // cycle on which the frame returns to IDLE
      if (i_report && (state != IDLE))
        o_drop <= 1'b1;
      case (state)
        IDLE: begin
          if (i_report) begin
            motor     <= i_motor;
            direction <= i_direction;
            rem       <= i_degrees;
            hund      <= '0;
            tens      <= '0;
            idx       <= '0;
            o_busy    <= 1'b1;
            state     <= CONV_H;
          end
        end
        CONV_H: begin
          if (rem >= 9'd100) begin
            rem  <= rem - 9'd100;
            hund <= hund + 4'd1;
          end else begin
            state <= CONV_T;
          end
        end
        CONV_T: begin
          if (rem >= 9'd10) begin
            rem  <= rem - 9'd10;
            tens <= tens + 4'd1;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: begin
          o_data <= frame_byte;
          state  <= SEND;
        end
        SEND: begin
          if (i_ready) begin
            o_start <= 1'b1;
            tmo     <= '0;
            state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // tmo counts completed WAIT_ACK cycles; the abort lands on the
          // ACK_TIMEOUT-th edge after entry
          if (!i_ready) begin
            state <= WAIT_DONE;
          end else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
            o_error <= 1'b1;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (i_ready) begin
            if (idx == 4'd8) begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end else begin
              idx   <= idx + 4'd1;
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_status_tx.sv
// Bench for motor_status_tx: a negedge uart_tx responder records every byte
// handed over; each test compares against frames computed from the field
// values with plain decimal arithmetic.
module tb_motor_status_tx;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b0;
  logic       i_report = 1'b0;
  logic [2:0] i_motor = '0;
  logic       i_direction = 1'b0;
  logic [8:0] i_degrees = '0;
  logic       i_ready;
  logic       o_start;
  logic [7:0] o_data;
  logic       o_busy;
  logic       o_drop;
  logic       o_error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // responder / monitor state
  logic [7:0] bytes[$];
  int   starts = 0;
  int   first_start = -1;
  int   last_start = -1;
  int   last_rise = -1;
  int   busy_fall = -1;
  int   error_cyc = -1;
  int   errs_seen = 0;
  int   drops_seen = 0;
  int   viol = 0;
  int   byte_time = 10;
  int   cnt = 0;
  bit   stuck = 1'b0;
  logic p_start = 1'b0, p_drop = 1'b0, p_err = 1'b0, p_busy = 1'b0;

  logic [7:0] exp_b[9];

  motor_status_tx #(.ACK_TIMEOUT(16)) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_report   (i_report),
    .i_motor    (i_motor),
    .i_direction(i_direction),
    .i_degrees  (i_degrees),
    .i_ready    (i_ready),
    .o_start    (o_start),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_drop     (o_drop),
    .o_error    (o_error)
  );

  initial forever #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) cyc = cyc + 1;

  // uart_tx model and output recorder, evaluated on the falling edge
  initial begin
    i_ready = 1'b1;
    forever begin
      @(negedge i_Clk);
      if (o_start) begin
        if (starts == 0) first_start = cyc;
        last_start = cyc;
        starts++;
        bytes.push_back(o_data);
      end
      if (o_drop) drops_seen++;
      if (o_error) begin
        errs_seen++;
        error_cyc = cyc;
      end
      if ((o_start && p_start) || (o_drop && p_drop) || (o_error && p_err)) viol++;
      if (p_busy && !o_busy) busy_fall = cyc;
      p_start = o_start;
      p_drop  = o_drop;
      p_err   = o_error;
      p_busy  = o_busy;
      if (i_Rst) begin
        i_ready = 1'b1;
        cnt = 0;
      end else if (o_start && !stuck) begin
        i_ready = 1'b0;
        cnt = byte_time;
      end else if (!i_ready) begin
        cnt--;
        if (cnt <= 0) begin
          i_ready = 1'b1;
          last_rise = cyc;
        end
      end
    end
  end

  task automatic make_exp(input logic [2:0] m, input logic d, input logic [8:0] deg);
    int v;
    v = int'(deg);
    exp_b[0] = 8'h4D;
    exp_b[1] = 8'(8'h30 + int'(m));
    exp_b[2] = 8'h44;
    exp_b[3] = 8'(8'h30 + int'(d));
    exp_b[4] = 8'(8'h30 + v / 100);
    exp_b[5] = 8'(8'h30 + (v / 10) % 10);
    exp_b[6] = 8'(8'h30 + v % 10);
    exp_b[7] = 8'h0D;
    exp_b[8] = 8'h0A;
  endtask

  task automatic start_frame(input logic [2:0] m, input logic d, input logic [8:0] deg,
                             output int e);
    @(negedge i_Clk);
    bytes.delete();
    starts = 0;
    first_start = -1;
    i_motor = m;
    i_direction = d;
    i_degrees = deg;
    i_report = 1'b1;
    @(negedge i_Clk);
    e = cyc;
    i_report = 1'b0;
    i_motor = 3'($urandom);
    i_direction = 1'($urandom);
    i_degrees = 9'($urandom);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (o_busy && k < budget) begin
      @(negedge i_Clk);
      k++;
    end
    if (o_busy) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: o_busy still 1 after %0d cycles", name, budget);
    end
    repeat (2) @(negedge i_Clk);
  endtask

  task automatic finish_frame(input string name, input logic [2:0] m, input logic d,
                              input logic [8:0] deg, input int e);
    int h, t;
    logic [7:0] got;
    wait_idle(name, 500);
    make_exp(m, d, deg);
    checks++;
    if (starts !== 9) begin
      errors++;
      $display("FAIL %s start count: got %0d expected 9", name, starts);
    end
    for (int k = 0; k < 9; k++) begin
      got = (k < bytes.size()) ? bytes[k] : 8'hxx;
      checks++;
      if (got !== exp_b[k]) begin
        errors++;
        $display("FAIL %s byte %0d: got %h expected %h", name, k, got, exp_b[k]);
      end
    end
    h = int'(deg) / 100;
    t = (int'(deg) / 10) % 10;
    checks++;
    if (first_start - e !== h + t + 4) begin
      errors++;
      $display("FAIL %s first start latency: got %0d expected %0d", name, first_start - e, h + t + 4);
    end
    checks++;
    if (busy_fall !== last_rise + 1) begin
      errors++;
      $display("FAIL %s busy fall: got cycle %0d expected %0d", name, busy_fall, last_rise + 1);
    end
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    #1;
    repeat (3) @(negedge i_Clk);
    checks++;
    if ({o_start, o_data, o_busy, o_drop, o_error} !== 12'h000) begin
      errors++;
      $display("FAIL reset outputs: got start=%b data=%h busy=%b drop=%b err=%b expected all 0",
               o_start, o_data, o_busy, o_drop, o_error);
    end
    i_Rst = 1'b0;
    repeat (2) @(negedge i_Clk);
    checks++;
    if ({o_start, o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset idle: got start=%b busy=%b expected 0 0", o_start, o_busy);
    end
  endtask

  task automatic test_frame(input string name, input logic [2:0] m, input logic d,
                            input logic [8:0] deg);
    int e;
    start_frame(m, d, deg, e);
    finish_frame(name, m, d, deg, e);
  endtask

  task automatic test_random();
    logic [2:0] m;
    logic d;
    logic [8:0] deg;
    for (int i = 0; i < 4; i++) begin
      m = 3'($urandom);
      d = 1'($urandom);
      deg = 9'($urandom_range(511, 0));
      test_frame("random", m, d, deg);
    end
  endtask

  task automatic test_busy_drop();
    int e, d0, k;
    d0 = drops_seen;
    start_frame(3'd5, 1'b0, 9'd347, e);
    k = 0;
    while (starts < 4 && k < 300) begin
      @(negedge i_Clk);
      k++;
    end
    i_motor = 3'd1;
    i_direction = 1'b1;
    i_degrees = 9'd12;
    i_report = 1'b1;
    @(negedge i_Clk);
    i_report = 1'b0;
    finish_frame("busy_drop", 3'd5, 1'b0, 9'd347, e);
    checks++;
    if (drops_seen - d0 !== 1) begin
      errors++;
      $display("FAIL busy_drop drop count: got %0d expected 1", drops_seen - d0);
    end
  endtask

  task automatic test_timeout();
    int e, k, e0;
    e0 = errs_seen;
    stuck = 1'b1;
    start_frame(3'd3, 1'b1, 9'd200, e);
    k = 0;
    while (!o_error && k < 200) begin
      @(negedge i_Clk);
      k++;
    end
    @(negedge i_Clk);
    checks++;
    if (error_cyc - first_start !== 16) begin
      errors++;
      $display("FAIL timeout error delay: got %0d expected 16", error_cyc - first_start);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout busy: got %b expected 0", o_busy);
    end
    repeat (30) @(negedge i_Clk);
    checks++;
    if (starts !== 1) begin
      errors++;
      $display("FAIL timeout start count: got %0d expected 1", starts);
    end
    checks++;
    if (errs_seen - e0 !== 1) begin
      errors++;
      $display("FAIL timeout error pulses: got %0d expected 1", errs_seen - e0);
    end
    stuck = 1'b0;
  endtask

  task automatic test_midframe_reset();
    int e, k, s0;
    start_frame(3'd6, 1'b0, 9'd458, e);
    k = 0;
    while (starts < 6 && k < 300) begin
      @(negedge i_Clk);
      k++;
    end
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b1;
    #1;
    checks++;
    if ({o_start, o_data, o_busy, o_drop, o_error} !== 12'h000) begin
      errors++;
      $display("FAIL midreset outputs: got start=%b data=%h busy=%b drop=%b err=%b expected all 0",
               o_start, o_data, o_busy, o_drop, o_error);
    end
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;
    s0 = starts;
    repeat (6) @(negedge i_Clk);
    checks++;
    if (starts !== s0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset quiet: got %0d new starts busy=%b expected 0 and 0", starts - s0, o_busy);
    end
    test_frame("after_reset", 3'd4, 1'b1, 9'd109);
  endtask

  task automatic test_same_cycle();
    int e, e2, k, target;
    start_frame(3'd7, 1'b1, 9'd64, e);
    k = 0;
    while (starts < 9 && k < 400) begin
      @(negedge i_Clk);
      k++;
    end
    target = last_start + byte_time;
    k = 0;
    while (cyc < target && k < 50) begin
      @(negedge i_Clk);
      k++;
    end
    i_motor = 3'd2;
    i_direction = 1'b0;
    i_degrees = 9'd305;
    i_report = 1'b1;
    @(negedge i_Clk);
    checks++;
    if ({o_busy, o_drop} !== 2'b01) begin
      errors++;
      $display("FAIL same_cycle first request: got busy=%b drop=%b expected 0 1", o_busy, o_drop);
    end
    @(negedge i_Clk);
    checks++;
    if ({o_busy, o_drop} !== 2'b10) begin
      errors++;
      $display("FAIL same_cycle second request: got busy=%b drop=%b expected 1 0", o_busy, o_drop);
    end
    e2 = cyc;
    i_report = 1'b0;
    bytes.delete();
    starts = 0;
    first_start = -1;
    finish_frame("same_cycle", 3'd2, 1'b0, 9'd305, e2);
  endtask

  task automatic test_pulses();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL pulse width: got %0d multi-cycle pulses expected 0", viol);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_frame("frame_90", 3'd2, 1'b1, 9'd90);
    test_frame("frame_511", 3'd0, 1'b0, 9'd511);
    test_frame("frame_0", 3'd7, 1'b1, 9'd0);
    test_random();
    test_busy_drop();
    test_timeout();
    test_midframe_reset();
    test_same_cycle();
    test_pulses();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motor_status_tx.md
# motor_status_tx

Formats a motor-command status report into an ASCII byte frame and feeds it to `uart_tx` one byte at a time over its start/ready handshake. It is the transmit-side counterpart of `data_state_machine`: that block parses ASCII digits into motor, direction and degree fields, and this block encodes those fields back into ASCII digits for the terminal. It sits between the command/motor logic, which raises `i_report`, and `uart_tx`.

## Interface
- `ACK_TIMEOUT`, default 16: cycles to wait for `i_ready` to fall after `o_start` before the frame is aborted.
- `i_Clk` input 1: system clock. One clock domain only.
- `i_Rst` input 1: asynchronous, active-high reset.
- `i_report` input 1: single-cycle request to send one frame.
- `i_motor` input 3: motor index, 0–7.
- `i_direction` input 1: rotation direction.
- `i_degrees` input 9: angle, 0–511, binary.
- `i_ready` input 1: from `uart_tx`. High means the transmitter is idle.
- `o_start` output 1: single-cycle byte-start pulse to `uart_tx`.
- `o_data` output 8: byte presented to `uart_tx`.
- `o_busy` output 1: high from request capture until the frame ends.
- `o_drop` output 1: single-cycle pulse when a request is ignored.
- `o_error` output 1: single-cycle pulse when a frame is aborted on ack timeout.

## Operation
- **Frame:** 9 bytes, sent in this order:
  - `'M'` (0x4D)
  - 0x30+motor
  - `'D'` (0x44)
  - 0x30+direction
  - hundreds digit, tens digit, units digit, each as 0x30+digit
  - 0x0D
  - 0x0A
- **Capture:** in IDLE, `i_report`=1 latches `i_motor`, `i_direction` and `i_degrees` into internal registers, and `o_busy` goes high. Inputs may change freely after the capture cycle.
- **States:** IDLE, CONV_H, CONV_T, LOAD, SEND, WAIT_ACK, WAIT_DONE.
- **CONV_H:** each cycle, if rem≥100, subtract 100 from rem and increment the hundreds digit; otherwise go to CONV_T.
- **CONV_T:** the same rule with 10, incrementing the tens digit; otherwise go to LOAD. The units digit is the remainder.
- **Digit range:** hundreds ≤5, tens ≤9, units ≤9. The remainder register is 9 bits and the digit registers are 4 bits each.
- **LOAD:** selects the byte at the current index (0–8) onto `o_data`, then goes to SEND.
- **SEND:** waits for `i_ready`=1, then drives `o_start`=1 for exactly one cycle and goes to WAIT_ACK.
- **Data hold:** `o_data` stays stable from LOAD until the state leaves WAIT_DONE.
- **WAIT_ACK:** waits for `i_ready`=0, then goes to WAIT_DONE.
  - A timeout counter is cleared on entry to WAIT_ACK.
  - If the counter reaches ACK_TIMEOUT, pulse `o_error`, drop `o_busy` and return to IDLE. The rest of the frame is discarded.
- **WAIT_DONE:** waits for `i_ready`=1.
  - If the index is 8, return to IDLE and drop `o_busy`.
  - Otherwise increment the index and go to LOAD.
- **Busy requests:** `i_report`=1 in any state other than IDLE pulses `o_drop` the next cycle. The frame in flight is unaffected and nothing is queued.
- **Same-cycle request:** `i_report` on the same cycle as the return to IDLE is treated as busy and dropped. It is accepted only when the state is IDLE at the clock edge.
- **Reset:** asynchronous at any time, including mid-frame.
  - State goes to IDLE and the index to 0.
  - `o_start`=0, `o_data`=0x00, `o_busy`=0, `o_drop`=0, `o_error`=0.
  - No partial byte is re-sent after reset.

## Timing
- **Reset values:** every output is 0 (`o_data` = 0x00).
- **Conversion:** cycle E is the capture edge. CONV_H takes h+1 cycles and CONV_T takes t+1 cycles, where h and t are the hundreds and tens digits.
  - degrees 0: 2 cycles.
  - degrees 511: 5+1+1+1 = 8 cycles.
- **First start:** with `i_ready` held at 1, the first `o_start` comes at E + 1 + (h+1) + (t+1) + 1 cycles.
- **Inter-byte gap:** minimum 2 cycles from `i_ready` rising in WAIT_DONE to the next `o_start` (LOAD, then SEND). The actual gap is set by the UART byte time.
- **Outputs:** all are registered. `o_start`, `o_drop` and `o_error` are never high for more than one consecutive cycle.

## Test plan
1. Motor=2, dir=1, deg=90, with a `uart_tx` model of 10-cycle bytes. Required byte sequence: 4D 32 44 31 30 39 30 0D 0A. Exactly 9 `o_start` pulses, and `o_busy` falls after the last `i_ready` rise.
2. deg=511 and deg=0. Digits must be 35 31 31 and 30 30 30. Check the first-`o_start` latency against the Timing formula: 8 and 2 conversion cycles respectively.
3. Assert `i_report` at byte index 3 with new field values. Required: one `o_drop` pulse, and the original frame completes unchanged.
4. Hold `i_ready`=1 permanently after the first `o_start`. Required: `o_error` pulses 16 cycles after WAIT_ACK entry, `o_busy`=0, and no further `o_start`.
5. Assert `i_Rst` mid-byte at index 5. All outputs must go to 0 immediately. A new request after release must send a full, correct 9-byte frame.
6. Assert `i_report` on the cycle `o_busy` falls. It must be dropped, and an identical request one cycle later must be accepted.
